// File: rtl/lm32_wb_arbiter_if.sv
// Wishbone classic link: master modport is the initiator side, slave modport the target side.
// Pure wiring, no latency; flow control is the cyc/stb vs ack/err handshake.
interface lm32_wb_arbiter_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        lock;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;

  modport master (
    output cyc, stb, we, lock, adr, dat_w, sel,
    input  dat_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, lock, adr, dat_w, sel,
    output dat_r, ack, err
  );
endinterface

// File: rtl/lm32_wb_arbiter.sv
// Two-master (I/D) to one-slave Wishbone arbiter with registered grant and per-access watchdog.
// One cycle to grant from IDLE; data/ack path combinational; a non-granted master simply waits.
module lm32_wb_arbiter #(
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  lm32_wb_arbiter_if.slave  i_bus,
  lm32_wb_arbiter_if.slave  d_bus,
  lm32_wb_arbiter_if.master s_bus,
  output logic              timeout_evt
);

  localparam int unsigned   CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO    = CW'(TIMEOUT);
  localparam bit            WD_EN  = (TIMEOUT != 0);
  localparam bit            D_WINS = (FIXED_PRIO != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_d_q, last_d_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        g_cyc, g_stb, g_we, g_lock;
  logic [31:0] g_adr, g_dat_w;
  logic [3:0]  g_sel;
  logic        waiting;
  logic        to_hit;

  // Request of whichever master currently owns the slave; all zero in IDLE.
  always_comb begin
    g_cyc   = 1'b0;
    g_stb   = 1'b0;
    g_we    = 1'b0;
    g_lock  = 1'b0;
    g_adr   = '0;
    g_dat_w = '0;
    g_sel   = '0;
    case (state_q)
      GNT_I: begin
        g_cyc   = i_bus.cyc;
        g_stb   = i_bus.stb;
        g_we    = i_bus.we;
        g_lock  = i_bus.lock;
        g_adr   = i_bus.adr;
        g_dat_w = i_bus.dat_w;
        g_sel   = i_bus.sel;
      end
      GNT_D: begin
        g_cyc   = d_bus.cyc;
        g_stb   = d_bus.stb;
        g_we    = d_bus.we;
        g_lock  = d_bus.lock;
        g_adr   = d_bus.adr;
        g_dat_w = d_bus.dat_w;
        g_sel   = d_bus.sel;
      end
      default: ;
    endcase
  end

  assign waiting = g_cyc & g_stb & ~s_bus.ack & ~s_bus.err;
  assign to_hit  = WD_EN && waiting && (cnt_q == TMO);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_bus.cyc && d_bus.cyc) begin
          state_d = (D_WINS || !last_d_q) ? GNT_D : GNT_I;
        end else if (d_bus.cyc) begin
          state_d = GNT_D;
        end else if (i_bus.cyc) begin
          state_d = GNT_I;
        end
      end
      GNT_I: begin
        if (!i_bus.cyc && !i_bus.lock) begin
          state_d = d_bus.cyc ? GNT_D : IDLE;
        end
      end
      GNT_D: begin
        if (!d_bus.cyc && !d_bus.lock) begin
          state_d = i_bus.cyc ? GNT_I : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    last_d_d = last_d_q;
    if (state_d == GNT_D) begin
      last_d_d = 1'b1;
    end else if (state_d == GNT_I) begin
      last_d_d = 1'b0;
    end

    // Any handover starts the new owner's wait count from zero.
    if ((state_d != state_q) || !waiting || to_hit || !WD_EN) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    s_bus.cyc   = g_cyc;
    s_bus.stb   = g_stb;
    s_bus.we    = g_we;
    s_bus.lock  = g_lock;
    s_bus.adr   = g_adr;
    s_bus.dat_w = g_dat_w;
    s_bus.sel   = g_sel;
    i_bus.dat_r = s_bus.dat_r;
    d_bus.dat_r = s_bus.dat_r;
    i_bus.ack   = 1'b0;
    i_bus.err   = 1'b0;
    d_bus.ack   = 1'b0;
    d_bus.err   = 1'b0;
    timeout_evt = to_hit;
    case (state_q)
      GNT_I: begin
        i_bus.ack = s_bus.ack;
        i_bus.err = s_bus.err | to_hit;
      end
      GNT_D: begin
        d_bus.ack = s_bus.ack;
        d_bus.err = s_bus.err | to_hit;
      end
      default: ;
    endcase
  end

endmodule
